// File: rtl/adc_spi_pkg.sv
// Shared definitions for the SPI ADC link (responder and master sides).
package adc_spi_pkg;

  // Result width of the emulated MCP3002.
  localparam int ADC_DATA_W = 10;

  // Command bits following the start bit: SGL/DIFF, ODD/SIGN, MSBF.
  localparam int CMD_BITS = 3;

  // Frame progress, counted from the observed CS_N fall.
  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    CMD,
    NULL_BIT,
    DATA,
    LSB,
    DONE
  } state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronizer for one SPI pin, with rise/fall detection on the synchronized level.
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Shift the pin through the synchronizer chain and keep one cycle of history.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_pin};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign o_level = sync_q[SYNC_STAGES-1];
  assign o_rise  = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign o_fall  = ~sync_q[SYNC_STAGES-1] & hist_q;

endmodule

// File: rtl/adc_spi_responder.sv
// ADC side of the SPI ADC link: decodes an MCP3002 command and shifts out a
// 10-bit result taken from the on-chip sample inputs.
module adc_spi_responder
  import adc_spi_pkg::*;
#(
  parameter int DATA_W      = ADC_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_sclk,
  input  logic              i_cs_n,
  input  logic              i_din,
  output logic              o_dout,
  output logic              o_dout_oe,
  input  logic [DATA_W-1:0] i_sample0,
  input  logic [DATA_W-1:0] i_sample1,
  output logic              o_req,
  output logic              o_chan,
  output logic              o_frame_err
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] LAST_LSB  = CNT_W'(DATA_W - 2);
  localparam logic [CNT_W-1:0] LAST_CMD  = CNT_W'(CMD_BITS - 1);

  // Synchronized pin views.
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic din_lvl, din_rise, din_fall;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_pin   (i_sclk),
    .o_level (sclk_lvl),
    .o_rise  (sclk_rise),
    .o_fall  (sclk_fall)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_pin   (i_cs_n),
    .o_level (cs_lvl),
    .o_rise  (cs_rise),
    .o_fall  (cs_fall)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_din (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_pin   (i_din),
    .o_level (din_lvl),
    .o_rise  (din_rise),
    .o_fall  (din_fall)
  );

  // Only edges of SCLK/CS_N and the level of DIN drive the frame.
  logic unused_sync;
  assign unused_sync = sclk_lvl ^ cs_lvl ^ din_rise ^ din_fall;

  // Frame state.
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic                sgl_q, sgl_d;
  logic                odd_q, odd_d;
  logic                msbf_q, msbf_d;
  logic [DATA_W-1:0]   snap_q, snap_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                dout_q, dout_d;
  logic                oe_q, oe_d;
  logic                req_q, req_d;
  logic                chan_q, chan_d;
  logic                ferr_q, ferr_d;

  // Conversion result for the command captured so far.
  logic [DATA_W:0]     diff_c;
  logic [DATA_W-1:0]   result_c;

  // Select single-ended sample or saturated pseudo-differential value.
  always_comb begin
    diff_c = odd_q ? ({1'b0, i_sample1} - {1'b0, i_sample0})
                   : ({1'b0, i_sample0} - {1'b0, i_sample1});
    if (sgl_q) begin
      result_c = odd_q ? i_sample1 : i_sample0;
    end else if (diff_c[DATA_W]) begin
      result_c = '0;
    end else begin
      result_c = diff_c[DATA_W-1:0];
    end
  end

  // Bit counter saturates so stray edges can never wrap it.
  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  // Next-state logic: CS_N rise overrides any SCLK edge seen in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sgl_d   = sgl_q;
    odd_d   = odd_q;
    msbf_d  = msbf_q;
    snap_d  = snap_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    oe_d    = oe_q;
    req_d   = 1'b0;
    chan_d  = chan_q;
    ferr_d  = 1'b0;

    if (cs_rise) begin
      state_d = IDLE;
      dout_d  = 1'b0;
      oe_d    = 1'b0;
      // A frame cut short before D0 is reported; LSB/DONE exits are clean.
      if (state_q == CMD || state_q == NULL_BIT || state_q == DATA) begin
        ferr_d = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          dout_d = 1'b0;
          oe_d   = 1'b0;
          if (cs_fall) begin
            state_d = WAIT_START;
          end
        end
        WAIT_START: begin
          // Leading zeros before the start bit are ignored.
          if (sclk_rise && din_lvl) begin
            state_d = CMD;
            cnt_d   = '0;
          end
        end
        CMD: begin
          if (sclk_rise) begin
            cnt_d = cnt_inc;
            if (cnt_q == '0) begin
              sgl_d = din_lvl;
            end else if (cnt_q != LAST_CMD) begin
              odd_d = din_lvl;
            end else begin
              // MSBF bit: take the snapshot used for the whole frame.
              msbf_d  = din_lvl;
              snap_d  = result_c;
              shift_d = result_c;
              req_d   = 1'b1;
              chan_d  = odd_q;
              state_d = NULL_BIT;
            end
          end
        end
        NULL_BIT: begin
          if (sclk_fall) begin
            dout_d  = 1'b0;
            oe_d    = 1'b1;
            cnt_d   = '0;
            state_d = DATA;
          end
        end
        DATA: begin
          if (sclk_fall) begin
            dout_d  = shift_q[DATA_W-1];
            shift_d = {shift_q[DATA_W-2:0], 1'b0};
            if (cnt_q == LAST_DATA) begin
              cnt_d = '0;
              if (msbf_q) begin
                state_d = DONE;
              end else begin
                // LSB-first tail starts at D1; D0 was just driven.
                state_d = LSB;
                shift_d = {1'b0, snap_q[DATA_W-1:1]};
              end
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        LSB: begin
          if (sclk_fall) begin
            dout_d  = shift_q[0];
            shift_d = {1'b0, shift_q[DATA_W-1:1]};
            if (cnt_q == LAST_LSB) begin
              cnt_d   = '0;
              state_d = DONE;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        DONE: begin
          // Hold the last bit for its full period, then park the line low.
          if (sclk_fall) begin
            dout_d = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          dout_d  = 1'b0;
          oe_d    = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sgl_q   <= 1'b0;
      odd_q   <= 1'b0;
      msbf_q  <= 1'b0;
      snap_q  <= '0;
      shift_q <= '0;
      dout_q  <= 1'b0;
      oe_q    <= 1'b0;
      req_q   <= 1'b0;
      chan_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sgl_q   <= sgl_d;
      odd_q   <= odd_d;
      msbf_q  <= msbf_d;
      snap_q  <= snap_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      oe_q    <= oe_d;
      req_q   <= req_d;
      chan_q  <= chan_d;
      ferr_q  <= ferr_d;
    end
  end

  assign o_dout      = dout_q;
  assign o_dout_oe   = oe_q;
  assign o_req       = req_q;
  assign o_chan      = chan_q;
  assign o_frame_err = ferr_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed and randomized SPI frames against a frame-level model of the ADC.
module tb_adc_spi_responder;

  localparam int DW = 10;

  logic          i_clk     = 1'b0;
  logic          i_rst_n   = 1'b0;
  logic          i_sclk    = 1'b0;
  logic          i_cs_n    = 1'b1;
  logic          i_din     = 1'b0;
  logic [DW-1:0] i_sample0 = 10'h2A5;
  logic [DW-1:0] i_sample1 = 10'h15A;
  logic          o_dout;
  logic          o_dout_oe;
  logic          o_req;
  logic          o_chan;
  logic          o_frame_err;

  int n_checks  = 0;
  int n_fail    = 0;
  int req_seen  = 0;
  int ferr_seen = 0;

  always #5 i_clk = ~i_clk;

  adc_spi_responder #(
    .DATA_W      (DW),
    .SYNC_STAGES (2)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_sclk      (i_sclk),
    .i_cs_n      (i_cs_n),
    .i_din       (i_din),
    .o_dout      (o_dout),
    .o_dout_oe   (o_dout_oe),
    .i_sample0   (i_sample0),
    .i_sample1   (i_sample1),
    .o_req       (o_req),
    .o_chan      (o_chan),
    .o_frame_err (o_frame_err)
  );

  // Count high cycles of the pulse outputs.
  always @(posedge i_clk) begin
    if (o_req) req_seen <= req_seen + 1;
    if (o_frame_err) ferr_seen <= ferr_seen + 1;
  end

  task automatic clks(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // MCP3002 result rule: single-ended channel or saturated pseudo-difference.
  function automatic int model_result(input bit sgl, input bit odd, input int s0, input int s1);
    int d;
    if (sgl) return odd ? s1 : s0;
    d = odd ? (s1 - s0) : (s0 - s1);
    return (d < 0) ? 0 : d;
  endfunction

  // One CS_N-low frame of nsclk SCLK periods. Bits are sampled by the master
  // just before each SCLK rise. rst_at >= 0 pulses reset in that period.
  task automatic frame(input string tag, input int lead, input bit sgl, input bit odd,
                       input bit msbf, input int nsclk, input int rst_at, input bit scramble);
    logic [31:0] exp_dout, exp_oe, got_dout, got_oe;
    int  res, req0, fe0, last_fall, tmp;
    bit  live, exp_req, exp_fe;
    live      = (rst_at < 0);
    res       = model_result(sgl, odd, int'(i_sample0), int'(i_sample1));
    last_fall = nsclk - 1;
    exp_req   = live && (last_fall >= lead + 3);
    exp_fe    = live && (last_fall >= lead) && (last_fall <= lead + 12);
    exp_dout  = '0;
    exp_oe    = '0;
    got_dout  = '0;
    got_oe    = '0;
    for (int r = 0; r < nsclk; r++) begin
      if (live) begin
        exp_oe[r] = (r >= lead + 4);
        if (r >= lead + 5 && r <= lead + 14) begin
          tmp = res >> (9 - (r - lead - 5));
          exp_dout[r] = tmp[0];
        end else if (!msbf && r >= lead + 15 && r <= lead + 23) begin
          tmp = res >> (r - lead - 14);
          exp_dout[r] = tmp[0];
        end
      end
    end

    req0   = req_seen;
    fe0    = ferr_seen;
    i_cs_n = 1'b0;
    clks(8);
    for (int r = 0; r < nsclk; r++) begin
      if (r < lead) i_din = 1'b0;
      else if (r == lead) i_din = 1'b1;
      else if (r == lead + 1) i_din = sgl;
      else if (r == lead + 2) i_din = odd;
      else if (r == lead + 3) i_din = msbf;
      else i_din = 1'($urandom_range(0, 1));
      if (scramble && r == lead + 6) begin
        i_sample0 = 10'($urandom_range(0, 1023));
        i_sample1 = 10'($urandom_range(0, 1023));
      end
      if (r == rst_at) begin
        i_rst_n = 1'b0;
        clks(2);
        i_rst_n = 1'b1;
        clks(2);
      end else begin
        clks(4);
      end
      got_dout[r] = o_dout;
      got_oe[r]   = o_dout_oe;
      i_sclk = 1'b1;
      clks(4);
      i_sclk = 1'b0;
    end
    clks(4);
    i_cs_n = 1'b1;
    clks(6);

    check($sformatf("%s dout", tag), got_dout, exp_dout);
    check($sformatf("%s oe", tag), got_oe, exp_oe);
    check($sformatf("%s idle_pins", tag), {30'b0, o_dout_oe, o_dout}, 32'h0);
    check($sformatf("%s req_cycles", tag), 32'(req_seen - req0), 32'(exp_req));
    check($sformatf("%s ferr_cycles", tag), 32'(ferr_seen - fe0), 32'(exp_fe));
    if (exp_req) check($sformatf("%s chan", tag), 32'(o_chan), 32'(odd));
    clks(8);
  endtask

  initial begin
    int lead, nsclk;
    bit sgl, odd, msbf;

    clks(3);
    check("reset_outputs", {27'b0, o_dout, o_dout_oe, o_req, o_chan, o_frame_err}, 32'h0);
    i_rst_n = 1'b1;
    clks(8);
    check("post_reset_ferr", 32'(ferr_seen), 32'h0);
    check("post_reset_req", 32'(req_seen), 32'h0);

    // Single-ended CH0, MSB-first.
    frame("t1_ch0", 0, 1'b1, 1'b0, 1'b1, 24, -1, 1'b0);
    // Back-to-back frames alternating channels.
    frame("t2_ch0", 0, 1'b1, 1'b0, 1'b1, 24, -1, 1'b0);
    frame("t2_ch1", 0, 1'b1, 1'b1, 1'b1, 24, -1, 1'b0);
    // Leading zeros and LSB-first tail.
    frame("t3_lsbf", 2, 1'b1, 1'b0, 1'b0, 26, -1, 1'b0);
    // Pseudo-differential, negative saturates and positive difference.
    i_sample0 = 10'h100;
    i_sample1 = 10'h180;
    frame("t4_diff_neg", 0, 1'b0, 1'b0, 1'b1, 24, -1, 1'b0);
    frame("t4_diff_pos", 0, 1'b0, 1'b1, 1'b1, 24, -1, 1'b0);
    i_sample0 = 10'h2A5;
    i_sample1 = 10'h15A;
    // Aborted after five data bits, then a clean frame.
    frame("t5_abort", 0, 1'b1, 1'b0, 1'b1, 10, -1, 1'b0);
    frame("t5_after", 0, 1'b1, 1'b0, 1'b1, 24, -1, 1'b0);
    // Reset mid-frame with CS_N low, then a clean frame.
    frame("t6_reset", 0, 1'b1, 1'b0, 1'b1, 24, 2, 1'b0);
    frame("t6_after", 0, 1'b1, 1'b0, 1'b1, 24, -1, 1'b0);

    // Randomized frames, samples changed after the snapshot.
    for (int i = 0; i < 16; i++) begin
      i_sample0 = 10'($urandom_range(0, 1023));
      i_sample1 = 10'($urandom_range(0, 1023));
      lead  = int'($urandom_range(0, 3));
      sgl   = 1'($urandom_range(0, 1));
      odd   = 1'($urandom_range(0, 1));
      msbf  = 1'($urandom_range(0, 1));
      nsclk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 23)) + lead : lead + 24;
      frame($sformatf("rand%0d", i), lead, sgl, odd, msbf, nsclk, -1, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
